// File: rtl/pwm_generator.sv
// Two-channel PWM generator with a shared prescaler/period counter and per-channel
// slew-limited duty updates applied only at period boundaries.
module pwm_generator #(
  parameter int PRESCALE  = 196,
  parameter int SLEW_STEP = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] pwm_duty_a,
  input  logic [7:0] pwm_duty_b,
  output logic       pwm_out_a,
  output logic       pwm_out_b,
  output logic       period_start,
  output logic       settled_a,
  output logic       settled_b
);

  localparam int DATA_W = 8;
  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);
  localparam logic signed [DATA_W+1:0] STEP = 10'(SLEW_STEP);
  localparam logic [DATA_W-1:0] STEP_U = 8'(SLEW_STEP);

  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN, HOLD} state_t;

  // Move active toward target by at most one slew step; the 10-bit signed
  // difference cannot wrap, so the result never overshoots or leaves 0..255.
  function automatic logic [DATA_W-1:0] slew(input logic [DATA_W-1:0] active,
                                              input logic [DATA_W-1:0] target);
    logic signed [DATA_W+1:0] diff;
    diff = $signed({2'b00, target}) - $signed({2'b00, active});
    if (diff > STEP)       return active + STEP_U;
    else if (diff < -STEP) return active - STEP_U;
    else                   return target;
  endfunction

  function automatic state_t classify(input logic [DATA_W-1:0] active,
                                      input logic [DATA_W-1:0] target);
    if (active == target)     return (target == '0) ? IDLE : HOLD;
    else if (active < target) return RAMP_UP;
    else                      return RAMP_DOWN;
  endfunction

  logic [15:0]       presc_p0;
  logic [DATA_W-1:0] period_p0;
  logic              tick;
  logic              boundary;

  assign tick     = (presc_p0 == PRESC_LAST);
  assign boundary = tick && (period_p0 == 8'hFF);

  // Stage 0: shared timebase
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_p0  <= '0;
      period_p0 <= '0;
    end else begin
      presc_p0 <= tick ? 16'd0 : presc_p0 + 16'd1;
      if (tick) period_p0 <= period_p0 + 8'd1;
    end
  end

  assign period_start = !reset && (presc_p0 == 16'd0) && (period_p0 == 8'd0);

  logic [1:0][DATA_W-1:0] duty;
  assign duty = {pwm_duty_b, pwm_duty_a};

  for (genvar c = 0; c < 2; c++) begin : g_chan
    logic [DATA_W-1:0] target;
    logic [DATA_W-1:0] active_p0;
    logic [DATA_W-1:0] active_nxt;
    state_t            state_p0;
    state_t            state_nxt;
    logic              pwm_p1;
    logic              settled_p1;

    assign target = enable ? duty[c] : '0;

    always_comb begin
      active_nxt = active_p0;
      state_nxt  = state_p0;
      if (boundary) begin
        active_nxt = slew(active_p0, target);
        state_nxt  = classify(active_nxt, target);
      end
    end

    // Stage 1: registered compare and status
    always_ff @(posedge clk) begin
      if (reset) begin
        active_p0  <= '0;
        state_p0   <= IDLE;
        pwm_p1     <= 1'b0;
        settled_p1 <= 1'b1;
      end else begin
        active_p0  <= active_nxt;
        state_p0   <= state_nxt;
        pwm_p1     <= (period_p0 < active_p0);
        settled_p1 <= (state_nxt == IDLE) || (state_nxt == HOLD);
      end
    end
  end

  assign pwm_out_a = g_chan[0].pwm_p1;
  assign pwm_out_b = g_chan[1].pwm_p1;
  assign settled_a = g_chan[0].settled_p1;
  assign settled_b = g_chan[1].settled_p1;

endmodule

// File: tb/tb_pwm_generator.sv
// Bench for pwm_generator: cycle-accurate arithmetic reference model checked every
// cycle, plus per-period high-count expectations derived by hand.
module tb_pwm_generator;
  localparam int PRESCALE = 2;
  localparam int SLEW     = 8;
  localparam int PLEN     = 256 * PRESCALE;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic [7:0] duty_a = 8'd0;
  logic [7:0] duty_b = 8'd0;
  logic       pwm_out_a, pwm_out_b, period_start, settled_a, settled_b;

  pwm_generator #(.PRESCALE(PRESCALE), .SLEW_STEP(SLEW)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .pwm_duty_a(duty_a), .pwm_duty_b(duty_b),
    .pwm_out_a(pwm_out_a), .pwm_out_b(pwm_out_b),
    .period_start(period_start), .settled_a(settled_a), .settled_b(settled_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit checking = 0;

  // Reference model: time since reset release drives everything.
  int m_t;
  int m_per;
  int m_act[2];
  int m_tgt[2];
  bit m_pwm[2];
  bit m_set[2];

  function automatic int step_toward(input int act, input int tgt);
    if (tgt > act) return act + (((tgt - act) < SLEW) ? (tgt - act) : SLEW);
    if (tgt < act) return act - (((act - tgt) < SLEW) ? (act - tgt) : SLEW);
    return act;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_t = 0;
      for (int c = 0; c < 2; c++) begin
        m_act[c] = 0; m_pwm[c] = 0; m_set[c] = 1;
      end
    end else begin
      m_per = (m_t / PRESCALE) % 256;
      m_tgt[0] = enable ? int'(duty_a) : 0;
      m_tgt[1] = enable ? int'(duty_b) : 0;
      for (int c = 0; c < 2; c++) begin
        m_pwm[c] = (m_per < m_act[c]);
        if (m_t % PLEN == PLEN - 1) begin
          m_act[c] = step_toward(m_act[c], m_tgt[c]);
          m_set[c] = (m_act[c] == m_tgt[c]);
        end
      end
      m_t++;
    end
  end

  always @(negedge clk) begin
    logic [4:0] exp_v, got_v;
    if (checking) begin
      exp_v = {m_pwm[0], m_pwm[1], (!reset && (m_t % PLEN == 0)), m_set[0], m_set[1]};
      got_v = {pwm_out_a, pwm_out_b, period_start, settled_a, settled_b};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL outputs t=%0t {pa,pb,ps,sa,sb} got=%b exp=%b", $time, got_v, exp_v);
      end
    end
  end

  // Per-period statistics gathered from the DUT outputs.
  int  k = 0;
  longint cyc = 0;
  int  a_cnt[64];
  int  b_cnt[64];
  bit  sa[64];
  bit  sb[64];
  longint pstart[64];

  always @(negedge clk) begin
    cyc++;
    if (reset) k = 0;
    else begin
      if (period_start && k < 63) begin
        k++;
        a_cnt[k] = 0; b_cnt[k] = 0;
        sa[k] = settled_a; sb[k] = settled_b;
        pstart[k] = cyc;
      end
      a_cnt[k] += int'(pwm_out_a);
      b_cnt[k] += int'(pwm_out_b);
    end
  end

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 checking = 1'b1;
    repeat (n - 1) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_k(input int n);
    int budget;
    budget = (n - k + 1) * PLEN + 16;
    while (k < n && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (k < n) begin
      checks++; errors++;
      $display("FAIL wait_period got=%0d exp=%0d", k, n);
    end
    #1;
  endtask

  initial begin
    // Idle with zero duty, then ramp A to 230 and B to 77
    do_reset(5);
    wait_k(3);
    check("idle_a_cnt1", a_cnt[1], 0);
    check("idle_b_cnt2", b_cnt[2], 0);
    check("idle_settled", {sa[2], sb[2]}, 2'b11);
    check("period_len", pstart[2] - pstart[1], PLEN);
    check("two_periods", pstart[3] - pstart[1], 2 * PLEN);
    duty_a = 8'd230; duty_b = 8'd77;
    wait_k(34);
    check("rampA_b1", a_cnt[4], 16);
    check("rampA_b28", a_cnt[31], 448);
    check("rampA_b29", a_cnt[32], 460);
    check("rampA_hold", a_cnt[33], 460);
    check("settledA_b28", sa[31], 0);
    check("settledA_b29", sa[32], 1);
    check("rampB_b9", b_cnt[12], 144);
    check("steadyB", b_cnt[13], 154);
    check("settledB", {sb[12], sb[13]}, 2'b01);
    check("model_act_a", m_act[0], 230);
    check("model_act_b", m_act[1], 77);

    // Mid-period command change is deferred to the next boundary
    duty_a = 8'd77; duty_b = 8'd0;
    do_reset(3);
    wait_k(12);
    repeat (199) @(posedge clk);
    #1 duty_a = 8'd120;
    wait_k(14);
    check("A77_p11", a_cnt[11], 154);
    check("A77_keep", a_cnt[12], 154);
    check("A85_next", a_cnt[13], 170);
    check("settled_hold", sa[11], 1);
    check("settled_ramp", sa[13], 0);

    // Soft stop with enable low, then restart
    duty_a = 8'd230; duty_b = 8'd230;
    do_reset(3);
    wait_k(31);
    check("both230_a", a_cnt[30], 460);
    check("both230_sb", sb[30], 1);
    enable = 1'b0;
    wait_k(61);
    check("down_first_a", a_cnt[32], 444);
    check("down_last_b", b_cnt[59], 12);
    check("down_zero_a", a_cnt[60], 0);
    check("idle_entry", {sa[59], sa[60], sb[60]}, 3'b011);
    enable = 1'b1;
    wait_k(63);
    check("restart_a", a_cnt[62], 16);
    check("restart_settled", sa[62], 0);

    // Randomized commands, enable toggles and one stray reset
    do_reset(3);
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(1, 150)) @(posedge clk);
      #1;
      duty_a = 8'($urandom_range(0, 255));
      duty_b = 8'($urandom_range(0, 255));
      enable = ($urandom_range(0, 3) != 0);
      if (i == 20) begin
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
      end
    end

    // Reset during a ramp at active A = 120
    duty_a = 8'd200; duty_b = 8'd0; enable = 1'b1;
    do_reset(3);
    wait_k(16);
    check("model_act_a_120", m_act[0], 120);
    check("ramp_p15_a", a_cnt[15], 224);
    repeat ($urandom_range(50, 200)) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_pwm_a", pwm_out_a, 0);
    check("rst_settled_a", settled_a, 1);
    check("rst_period_start", period_start, 0);
    @(posedge clk); #1 reset = 1'b0;
    wait_k(3);
    check("post_rst_len", pstart[2] - pstart[1], PLEN);
    check("post_rst_a1", a_cnt[1], 0);
    check("post_rst_a2", a_cnt[2], 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
